// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch port and the data port.
// Define MEM_ARB_IBUF_EN to compile in a one-entry fetch buffer (tag/data/valid).
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  output logic                 i_stall,
  input  logic                 d_read,
  input  logic                 d_write,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 d_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 i_done_q, i_done_d;
  logic                 d_done_q, d_done_d;

  logic                 d_pend_s;
  logic                 arb_s;
  logic                 grant_d_s;
  logic                 grant_i_s;
  logic                 ibuf_hit_s;
  logic [WORD_SIZE-1:0] ibuf_data_s;

  // Data wins a tie unless it also won the previous grant, so neither side starves.
  assign d_pend_s  = d_read | d_write;
  assign arb_s     = (state_q == IDLE) || (state_q == RESP);
  assign grant_d_s = arb_s & d_pend_s & (~i_req | (last_grant_q == GRANT_FETCH));
  assign grant_i_s = arb_s & i_req & ~grant_d_s;

`ifdef MEM_ARB_IBUF_EN
  logic                 ibuf_valid_q, ibuf_valid_d;
  logic [WORD_SIZE-1:0] ibuf_tag_q, ibuf_tag_d;
  logic [WORD_SIZE-1:0] ibuf_data_q, ibuf_data_d;

  assign ibuf_hit_s  = grant_i_s & ibuf_valid_q & (i_addr == ibuf_tag_q);
  assign ibuf_data_s = ibuf_data_q;

  // Refill on every completed memory fetch; a store to the buffered address invalidates it.
  always_comb begin
    ibuf_valid_d = ibuf_valid_q;
    ibuf_tag_d   = ibuf_tag_q;
    ibuf_data_d  = ibuf_data_q;
    if ((state_q == I_BUSY) && mem_ready) begin
      ibuf_valid_d = 1'b1;
      ibuf_tag_d   = mem_addr_q;
      ibuf_data_d  = mem_rdata;
    end else if (grant_d_s && d_write && (d_addr == ibuf_tag_q)) begin
      ibuf_valid_d = 1'b0;
    end else begin
      ibuf_valid_d = ibuf_valid_q;
    end
  end

  // Fetch buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= {WORD_SIZE{1'b0}};
      ibuf_data_q  <= {WORD_SIZE{1'b0}};
    end else begin
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_tag_q   <= ibuf_tag_d;
      ibuf_data_q  <= ibuf_data_d;
    end
  end
`else
  assign ibuf_hit_s  = 1'b0;
  assign ibuf_data_s = {WORD_SIZE{1'b0}};
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_FETCH;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {WORD_SIZE{1'b0}};
      mem_wdata_q  <= {WORD_SIZE{1'b0}};
      i_rdata_q    <= {WORD_SIZE{1'b0}};
      d_rdata_q    <= {WORD_SIZE{1'b0}};
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
    end
  end

  // Next-state logic; a buffered fetch skips straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant_d_s) begin
          state_d = D_BUSY;
        end else if (grant_i_s) begin
          state_d = ibuf_hit_s ? RESP : I_BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      I_BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
        end else begin
          state_d = I_BUSY;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
        end else begin
          state_d = D_BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic: latch the access on grant, capture read data on completion.
  always_comb begin
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (grant_d_s) begin
          last_grant_d = GRANT_DATA;
          mem_req_d    = 1'b1;
          mem_we_d     = d_write;
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
        end else if (grant_i_s) begin
          last_grant_d = GRANT_FETCH;
          if (ibuf_hit_s) begin
            i_done_d  = 1'b1;
            i_rdata_d = ibuf_data_s;
          end else begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = i_addr;
          end
        end else begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      I_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          i_done_d  = 1'b1;
          i_rdata_d = mem_rdata;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      D_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we_q) begin
            d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);
  assign i_stall   = i_req & ~i_done_q;
  assign d_stall   = d_pend_s & ~d_done_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and its data (MEM-stage) port. It sits between the 5-stage datapath and the memory model. It serialises accesses with a small FSM, registers read data and completion pulses back to each requester, and drives the stall conditions the pipeline uses to freeze IF or MEM while an access is outstanding.

## Interface
- `WORD_SIZE`, 16, data/address width.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_done`.
- `i_addr`  in  WORD_SIZE  fetch address (PC).
- `i_rdata`  out  WORD_SIZE  registered fetched instruction.
- `i_done`  out  1  one-cycle fetch completion pulse.
- `i_stall`  out  1  `i_req & ~i_done` (combinational).
- `d_read`, `d_write`  in  1 each  data request; never both high; held until `d_done`.
- `d_addr`  in  WORD_SIZE  data address.
- `d_wdata`  in  WORD_SIZE  store data. The bidirectional `data2` split is done outside this block.
- `d_rdata`  out  WORD_SIZE  registered load data.
- `d_done`  out  1  one-cycle data completion pulse.
- `d_stall`  out  1  `(d_read|d_write) & ~d_done` (combinational).
- `mem_req`  out  1  memory access active.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  WORD_SIZE  latched address.
- `mem_wdata`  out  WORD_SIZE  latched store data.
- `mem_rdata`  in  WORD_SIZE  memory read data, valid with `mem_ready`.
- `mem_ready`  in  1  access complete, sampled at posedge.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states:
  - IDLE
  - I_BUSY
  - D_BUSY
  - RESP
- Arbitration happens in IDLE and RESP:
  - If a data request and `i_req` are both pending, data wins unless the previous grant was data. In that case fetch wins. A one-bit `last_grant` register enforces this alternation, so neither requester starves.
  - Only the data request pending → D_BUSY.
  - Only `i_req` pending → I_BUSY.
  - Nothing pending → IDLE.
- On grant, latch the address, write enable and write data into the `mem_*` registers, and set `mem_req` = 1.
- In I_BUSY or D_BUSY, hold `mem_*` stable until `mem_ready` = 1 at a posedge, then go to RESP:
  - On a read, capture `mem_rdata` into `i_rdata` or `d_rdata`.
  - Clear `mem_req`.
  - Pulse the matching `*_done` for exactly the RESP cycle.
- Requesters must drop or update their request during the done cycle. A request still high at the RESP-exit edge is treated as a new access.
- `i_rdata`/`d_rdata` hold their value until the next completed read on the same port. Writes leave `d_rdata` unchanged.
- A request that arrives while the FSM is busy waits. It is considered at the next RESP arbitration.
- `mem_ready` outside I_BUSY/D_BUSY is ignored.

## Timing
- Reset values:
  - State: IDLE.
  - `last_grant`: fetch.
  - `mem_req`, `mem_we`, `i_done`, `d_done`: 0.
  - `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`: 0.
  - `busy`: 0.
- Reset asserted mid-access aborts the access immediately and asynchronously: `mem_req` drops and no done pulse is issued.
- A request is seen at edge E0. With a 1-cycle memory (`mem_ready` sampled at E1), done is high during E1→E2 and the next grant is possible at E2.
- Throughput is 1 access per 2 cycles, plus any extra memory wait cycles.
- `mem_ready` arriving in the same cycle as grant cannot complete the access. The earliest completion is the edge after grant.
- Done outputs are registered and never combinationally depend on `mem_ready`.

## Configuration
- `MEM_ARB_IBUF_EN` defined: a one-entry fetch buffer (tag, data, valid) is compiled in.
  - A fetch granted with `i_addr == tag` and valid goes directly to RESP with the buffered data, and `mem_req` stays 0.
  - Every completed memory fetch refills the buffer.
  - A data write whose address equals the tag clears valid. The write is granted and completes normally.
  - The buffer is invalid on reset.
- `MEM_ARB_IBUF_EN` undefined: every fetch goes through I_BUSY with a real memory access. There are no tag or data registers.

## Test plan
- Reset, then `i_req` = 1 with `i_addr` = 0x0000 and memory returning 0x6000 with 1-cycle ready:
  - `mem_req` = 1 with `mem_addr` = 0x0000 from E0.
  - `i_done` = 1 and `i_rdata` = 0x6000 during E1→E2.
  - `d_done` stays 0.
- `d_read` (`d_addr` = 0x0040) and `i_req` (0x0005) both rise at the same edge from IDLE, with `last_grant` = fetch:
  - Data is granted first and `d_rdata` = the memory word.
  - Fetch is granted at the RESP exit.
  - `i_stall` stays high throughout.
- Back-to-back `d_write` requests (0x0010 ← 0x1234, then 0x0011 ← 0x5678) with `i_req` held:
  - Grants go D, I, D.
  - `mem_we` = 1 only in the D_BUSY states.
  - Memory holds 0x1234 and 0x5678.
- Memory with 3-cycle `mem_ready` on a fetch:
  - `mem_addr` stays constant for 3 cycles.
  - `i_done` is a single-cycle pulse.
  - `busy` = 1 from grant through RESP.
- Reset pulse while in D_BUSY:
  - `mem_req`, `d_done` and `busy` go 0 immediately.
  - After release, a new `i_req` is served normally.
- `MEM_ARB_IBUF_EN` only:
  - Fetch 0x0003 twice: the second fetch completes with `mem_req` never asserted.
  - Then `d_write` to 0x0003 followed by fetch 0x0003: the fetch goes to memory and returns the newly written value.
